// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, frame geometry and scan-code
// constants also used by the downstream break-code filter.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DPS  = 2'd1,
        ST_LOAD = 2'd2
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DPS_BITS   = 10;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx_chk_if.sv
// PS/2 receiver bundle: raw bus lines and enable in, decoded byte and strobes out.
interface ps2_rx_chk_if;
    logic       ps2d;
    logic       ps2c;
    logic       rx_en;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_tick;

    modport master (
        output ps2d, ps2c, rx_en,
        input  rx_done_tick, dout, parity_err, frame_err, timeout_tick
    );

    modport slave (
        input  ps2d, ps2c, rx_en,
        output rx_done_tick, dout, parity_err, frame_err, timeout_tick
    );
endinterface

// File: rtl/ps2_filter.sv
// Synchronises the raw PS/2 lines, glitch-filters the clock and flags the
// filtered clock's falling edge together with the synchronised data bit.
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic data_sync
);

    logic [1:0]            c_sync_q, c_sync_d;
    logic [1:0]            d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] shreg_q,  shreg_d;
    logic                  filt_q,   filt_d;

    // Next-state: shift synchronisers and filter, hysteretic filtered level.
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        shreg_d  = {shreg_q[FILTER_LEN-2:0], c_sync_q[1]};
        if (&shreg_q) begin
            filt_d = 1'b1;
        end else if (~|shreg_q) begin
            filt_d = 1'b0;
        end else begin
            filt_d = filt_q;
        end
    end

    // Registers preload to 1 so an idle-high bus never yields a fall after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            shreg_q  <= {FILTER_LEN{1'b1}};
            filt_q   <= 1'b1;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            shreg_q  <= shreg_d;
            filt_q   <= filt_d;
        end
    end

    assign fall      = filt_q & ~filt_d;
    assign data_sync = d_sync_q[1];

endmodule

// File: rtl/ps2_rx_chk.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, flags parity/stop
// errors, aborts stalled frames and strobes one byte per frame.
module ps2_rx_chk
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_rx_chk_if.slave  bus
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic fall_s;
    logic data_s;

    ps2_state_e              state_q, state_d;
    logic [3:0]              n_q,     n_d;
    logic [PS2_DPS_BITS-1:0] b_q,     b_d;
    logic [TMR_W-1:0]        tmr_q,   tmr_d;
    logic                    done_q,  done_d;
    logic                    tmo_q,   tmo_d;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (bus.ps2c),
        .ps2d      (bus.ps2d),
        .fall      (fall_s),
        .data_sync (data_s)
    );

    // Frame FSM next-state; strobes are computed here and registered below.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        b_d     = b_q;
        tmr_d   = tmr_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_s && bus.rx_en && !data_s) begin
                    state_d = ST_DPS;
                    n_d     = 4'(PS2_DPS_BITS - 1);
                    tmr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DPS: begin
                if (fall_s) begin
                    b_d   = {data_s, b_q[PS2_DPS_BITS-1:1]};
                    tmr_d = '0;
                    if (n_q == 4'd0) begin
                        state_d = ST_LOAD;
                        done_d  = 1'b1;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_LOAD: begin
                // Any fall seen here is ignored; the bus cannot legally be that fast.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= 4'd0;
            b_q     <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.rx_done_tick = done_q;
    assign bus.timeout_tick = tmo_q;
    assign bus.dout         = b_q[7:0];
    assign bus.parity_err   = ~odd_parity_ok(b_q[8:0]);
    assign bus.frame_err    = ~b_q[9];

endmodule

// File: tb/tb_ps2_rx_chk.sv
// Directed bench for ps2_rx_chk: frames pushed to a scoreboard when sent,
// popped and checked when the receiver strobes rx_done_tick.
module tb_ps2_rx_chk;
    import ps2_pkg::*;

    // Shortened timeout and fast PS/2 clock keep the run short.
    localparam int F    = 8;
    localparam int T    = 2000;
    localparam int HALF = 40;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    ps2_rx_chk_if bus();

    ps2_rx_chk #(.FILTER_LEN(F), .TIMEOUT_CYC(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tick_cnt = 0;
    int tmo_cnt  = 0;
    int last_tick_cyc = 0;
    int last_tmo_cyc  = 0;
    int fall_cyc      = 0;

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_done_tick) begin
                tick_cnt++;
                last_tick_cyc = cyc;
                chk("tick_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dout", 32'(bus.dout), 32'(e.d));
                    chk("parity_err", 32'(bus.parity_err), 32'(e.pe));
                    chk("frame_err", 32'(bus.frame_err), 32'(e.fe));
                end
            end
            if (bus.timeout_tick) begin
                tmo_cnt++;
                last_tmo_cyc = cyc;
            end
        end
    end

    task automatic wcyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        bus.ps2d = v;
        wcyc(HALF);
        bus.ps2c = 1'b0;
        fall_cyc = cyc;
        wcyc(HALF);
        bus.ps2c = 1'b1;
        if (glitch) begin
            wcyc(15);
            bus.ps2c = 1'b0;
            wcyc(3);
            bus.ps2c = 1'b1;
            wcyc(HALF - 18);
        end
    endtask

    // nbits = bits sent after the start bit (10 = complete frame).
    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                              input logic glitch, input int nbits, input logic push,
                              input logic drop_en);
        logic [10:0] frm;
        frm = {stop, (~^d) ^ pflip, d, 1'b0};
        if (push) exp_q.push_back({d, pflip, ~stop});
        for (int i = 0; i <= nbits; i++) begin
            send_bit(frm[i], glitch);
            if (i == 0 && drop_en) bus.rx_en = 1'b0;
        end
        bus.ps2d  = 1'b1;
        bus.rx_en = 1'b1;
    endtask

    task automatic settle(input string tag);
        wcyc(HALF);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int tc;
        bus.ps2c  = 1'b1;
        bus.ps2d  = 1'b1;
        bus.rx_en = 1'b1;
        reset     = 1'b1;
        wcyc(5);
        @(negedge clk);
        chk("rst_done", 32'(bus.rx_done_tick), 32'd0);
        chk("rst_tmo", 32'(bus.timeout_tick), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'h00);
        chk("rst_perr", 32'(bus.parity_err), 32'd1);
        chk("rst_ferr", 32'(bus.frame_err), 32'd1);
        reset = 1'b0;
        wcyc(20);

        // Clean 0x1C and its exact strobe latency.
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0);
        settle("q_clean");
        chk("latency", 32'(last_tick_cyc - fall_cyc), 32'(F + 3));
        chk("ticks_1", 32'(tick_cnt), 32'd1);

        // Parity error, then a clean break code.
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b0);
        send_frame(PS2_BRK, 1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0);
        settle("q_parity");

        // Stop bit 0, then a clean frame.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0);
        settle("q_stop");

        // Short clock glitches between every bit.
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b0);
        settle("q_glitch");
        chk("ticks_6", 32'(tick_cnt), 32'd6);

        // Start + 4 data bits, then stall until timeout.
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0);
        tc = 0;
        while (tmo_cnt == 0 && tc < T + 500) begin
            wcyc(1);
            tc++;
        end
        chk("tmo_seen", 32'(tmo_cnt), 32'd1);
        chk("tmo_latency", 32'(last_tmo_cyc - fall_cyc), 32'(T + F + 3));
        wcyc(200);
        chk("tmo_single", 32'(tmo_cnt), 32'd1);
        chk("tmo_no_tick", 32'(tick_cnt), 32'd6);

        // Next frame after timeout; rx_en dropped right after the start bit.
        send_frame(PS2_BRK, 1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b1);
        settle("q_after_tmo");

        // One-cycle reset after data bit 6, then a full 0x29.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 7, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_dout", 32'(bus.dout), 32'h00);
        chk("mid_rst_done", 32'(bus.rx_done_tick), 32'd0);
        wcyc(20);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0);
        settle("q_after_rst");
        chk("ticks_8", 32'(tick_cnt), 32'd8);

        // rx_en low across the whole frame: ignored.
        bus.rx_en = 1'b0;
        wcyc(5);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0);
        bus.rx_en = 1'b0;
        wcyc(HALF);
        bus.rx_en = 1'b1;
        chk("rx_en_gated", 32'(tick_cnt), 32'd8);
        chk("held_dout", 32'(bus.dout), 32'h29);
        chk("tmo_total", 32'(tmo_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
